jump_ctrl: RTL and testbench
============================

Name: jump_ctrl

Overview:
- Control stage directly upstream of the program counter; drives its jumpEn and target inputs every cycle.
- Resolves three request kinds:
  - conditional branches through a small writable target lookup table (LUT);
  - calls, which jump and push a return address;
  - returns, which pop that address.
- Decode drives the requests. The ALU supplies the branch condition flag.

Parameters:
D, 6, program counter / target width in bits (matches the PC).
L, 3, LUT index width; the LUT has 2**L entries of D bits.
S, 4, return-address stack depth in entries (S >= 2).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
programCounter  input  D  current PC value from the PC stage
brEn  input  1  conditional branch request this cycle
cond  input  1  branch condition flag; branch taken when 1
callEn  input  1  call request; unconditional jump to LUT target, push return address
retEn  input  1  return request; jump to popped address
brIdx  input  L  LUT index for branch and call targets
lutWrEn  input  1  LUT write strobe
lutWrIdx  input  L  LUT write index
lutWrData  input  D  LUT write data
jumpEn  output  1  to PC: load target at next edge
target  output  D  to PC: jump destination; 0 whenever jumpEn=0
stackEmpty  output  1  return stack holds 0 entries
stackFull  output  1  return stack holds S entries
stackErr  output  1  sticky: overflow or underflow occurred

Behaviour:
- Reset is synchronous, active-high, and dominates all other inputs.
  - On the reset edge: all LUT entries = 0, stack pointer = 0, stackErr = 0.
  - While reset=1, jumpEn is forced 0 and target is forced 0.
  - Out of reset: stackEmpty=1, stackFull=0, stackErr=0.
- jumpEn and target are combinational from the current request inputs and registered state, so there is zero latency. The PC applies them at the next rising edge, with no delay slot.
- Priority when several requests are asserted together: retEn > callEn > brEn. Lower-priority requests are ignored that cycle; this is not an error.
- Branch (brEn=1, no higher-priority request):
  - cond=1: jumpEn=1, target=LUT[brIdx].
  - cond=0: jumpEn=0.
  - Stack is unchanged in both cases.
- Call (callEn=1, retEn=0):
  - Stack not full: jumpEn=1, target=LUT[brIdx]. At the edge, push programCounter+1, truncated to D bits (the maximum PC wraps to 0), and increment the pointer.
  - Stack full: jumpEn=0, no push; stackErr sets at the edge.
- Return (retEn=1):
  - Stack not empty: jumpEn=1, target=top entry. At the edge, decrement the pointer.
  - Stack empty: jumpEn=0, no pop; stackErr sets at the edge.
- The stack is a LIFO of S entries, and the pointer ranges over 0..S.
  - stackEmpty = (ptr == 0).
  - stackFull = (ptr == S).
  - Both flags are registered-state derived, with no combinational path from the requests.
- stackErr clears only on reset.
- LUT write:
  - When lutWrEn=1, LUT[lutWrIdx] takes lutWrData at the edge.
  - A same-cycle read of the same index returns the OLD value (read-before-write).
  - Writes are independent of jump requests.
- There are no other states; the block is pure request-response around the stack and LUT registers.

Decomposition:
- Shared package jump_pkg holds:
  - enum typedef jreq_t {J_NONE, J_BR, J_CALL, J_RET}, produced by the priority encoder;
  - default localparams for D, L, S, shared with the PC and decode.
- Sub-module ret_stack(D, S):
  - ports: clk, reset, push, pop, din, dout (top), empty, full;
  - guards push-on-full and pop-on-empty internally (no state change);
  - jump_ctrl derives stackErr from the same conditions.

Test Plan:
- Reset, then idle: jumpEn=0, target=0, stackEmpty=1, stackFull=0, stackErr=0. LUT entries read 0 via brEn=1, cond=1 (jumpEn=1, target=0).
- LUT write and branch:
  - Write LUT[5]=0x2A, then brEn=1, brIdx=5, cond=1: jumpEn=1, target=0x2A.
  - Same with cond=0: jumpEn=0, target=0.
  - Same-cycle write of LUT[5]=0x11 with read of 5: target=0x2A; the next cycle reads 0x11.
- Call/return nesting:
  - LUT[1]=0x10; call at PC=0x05, then call at PC=0x12: pushes 0x06, 0x13.
  - ret: target=0x13; second ret: target=0x06; stackEmpty=1 afterwards.
- Overflow and wrap (S=4):
  - 4 calls succeed; stackFull=1.
  - 5th call: jumpEn=0, stackErr=1; stack contents unchanged, confirmed by 4 rets returning pushed addresses in reverse order.
  - Call at PC=0x3F pushes 0x00.
- Underflow and priority:
  - ret on empty stack: jumpEn=0, stackErr=1, pointer stays 0.
  - With 1 entry, assert retEn, callEn and brEn together: return taken, no push.
- Reset mid-operation: after 3 pushes and stackErr=1, assert reset with callEn=1. jumpEn=0 during reset; afterwards stackEmpty=1, stackErr=0, LUT all 0.

Source files
------------

// File: rtl/jump_ctrl_pkg.sv
// Shared jump-control types and default widths, also used by the PC and decode stages.
package jump_pkg;

  localparam int unsigned D_DEF = 6;
  localparam int unsigned L_DEF = 3;
  localparam int unsigned S_DEF = 4;

  typedef enum logic [1:0] {J_NONE, J_BR, J_CALL, J_RET} jreq_t;

  // Return beats call, and call beats branch; lower requests are dropped silently.
  function automatic jreq_t prio_enc(input logic ret, input logic call, input logic br);
    if (ret)       return J_RET;
    else if (call) return J_CALL;
    else if (br)   return J_BR;
    else           return J_NONE;
  endfunction

endpackage

// File: rtl/jump_ctrl_if.sv
// Request/response bundle between decode/ALU/PC and the jump control stage.
interface jump_ctrl_if #(
  parameter int unsigned D = jump_pkg::D_DEF,
  parameter int unsigned L = jump_pkg::L_DEF
);
  logic [D-1:0] programCounter;
  logic         brEn;
  logic         cond;
  logic         callEn;
  logic         retEn;
  logic [L-1:0] brIdx;
  logic         lutWrEn;
  logic [L-1:0] lutWrIdx;
  logic [D-1:0] lutWrData;
  logic         jumpEn;
  logic [D-1:0] target;
  logic         stackEmpty;
  logic         stackFull;
  logic         stackErr;

  modport master (
    output programCounter, brEn, cond, callEn, retEn, brIdx,
           lutWrEn, lutWrIdx, lutWrData,
    input  jumpEn, target, stackEmpty, stackFull, stackErr
  );

  modport slave (
    input  programCounter, brEn, cond, callEn, retEn, brIdx,
           lutWrEn, lutWrIdx, lutWrData,
    output jumpEn, target, stackEmpty, stackFull, stackErr
  );
endinterface

// File: rtl/jump_ctrl_ret_stack.sv
// Return-address LIFO; push-on-full and pop-on-empty leave the state untouched.
module ret_stack #(
  parameter int unsigned D = 6,
  parameter int unsigned S = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] din,
  output logic [D-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int unsigned PW = $clog2(S + 1);

  // Storage is sized to the pointer range so the pointer indexes it directly.
  logic [D-1:0]  mem [2**PW];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_ptr;

  assign empty   = (ptr == '0);
  assign full    = (ptr == PW'(S));
  assign top_ptr = ptr - PW'(1);
  assign dout    = empty ? '0 : mem[top_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (push && !full) begin
      mem[ptr] <= din;
      ptr      <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= top_ptr;
    end
  end
endmodule

// File: rtl/jump_ctrl.sv
// Resolves branch/call/return requests into a same-cycle jumpEn/target for the PC.
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int unsigned D = D_DEF,
  parameter int unsigned L = L_DEF,
  parameter int unsigned S = S_DEF
) (
  input  logic        clk,
  input  logic        reset,
  jump_ctrl_if.slave  bus
);
  logic [D-1:0] lut [2**L];
  logic [D-1:0] stk_dout;
  logic         stk_empty;
  logic         stk_full;
  logic         push;
  logic         pop;
  logic         err_set;
  logic         err_q;
  jreq_t        req;

  ret_stack #(.D(D), .S(S)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.programCounter + D'(1)),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign req = prio_enc(bus.retEn, bus.callEn, bus.brEn);

  always_comb begin
    bus.jumpEn = 1'b0;
    bus.target = '0;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    if (!reset) begin
      unique case (req)
        J_BR: begin
          if (bus.cond) begin
            bus.jumpEn = 1'b1;
            bus.target = lut[bus.brIdx];
          end
        end
        J_CALL: begin
          if (stk_full) begin
            err_set = 1'b1;
          end else begin
            bus.jumpEn = 1'b1;
            bus.target = lut[bus.brIdx];
            push       = 1'b1;
          end
        end
        J_RET: begin
          if (stk_empty) begin
            err_set = 1'b1;
          end else begin
            bus.jumpEn = 1'b1;
            bus.target = stk_dout;
            pop        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reads above are combinational from the current array, so a same-edge write is seen next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2**L; i++) lut[i] <= '0;
      err_q <= 1'b0;
    end else begin
      if (bus.lutWrEn) lut[bus.lutWrIdx] <= bus.lutWrData;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.stackEmpty = stk_empty;
  assign bus.stackFull  = stk_full;
  assign bus.stackErr   = err_q;
endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl: LUT, branch, call/return nesting, overflow/underflow, reset.
module tb_jump_ctrl;
  localparam int unsigned D = 6;
  localparam int unsigned L = 3;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  jump_ctrl_if #(.D(D), .L(L)) bus ();

  jump_ctrl #(.D(D), .L(L), .S(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.programCounter = '0;
    bus.brEn = 1'b0; bus.cond = 1'b0; bus.callEn = 1'b0; bus.retEn = 1'b0;
    bus.brIdx = '0;
    bus.lutWrEn = 1'b0; bus.lutWrIdx = '0; bus.lutWrData = '0;
  endtask

  task automatic lut_write(input logic [L-1:0] idx, input logic [D-1:0] data);
    idle();
    bus.lutWrEn = 1'b1; bus.lutWrIdx = idx; bus.lutWrData = data;
    tick();
    idle();
  endtask

  task automatic call(input logic [D-1:0] pc, input logic [D-1:0] exp_tgt);
    idle();
    bus.callEn = 1'b1; bus.brIdx = 3'd1; bus.programCounter = pc;
    #1;
    check("call_jump", 32'(bus.jumpEn), 32'd1);
    check("call_tgt", 32'(bus.target), 32'(exp_tgt));
    tick();
    idle();
  endtask

  task automatic ret(input logic [D-1:0] exp_tgt);
    idle();
    bus.retEn = 1'b1;
    #1;
    check("ret_jump", 32'(bus.jumpEn), 32'd1);
    check("ret_tgt", 32'(bus.target), 32'(exp_tgt));
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_jump", 32'(bus.jumpEn), 32'd0);
    check("rst_tgt", 32'(bus.target), 32'd0);
    check("rst_empty", 32'(bus.stackEmpty), 32'd1);
    check("rst_full", 32'(bus.stackFull), 32'd0);
    check("rst_err", 32'(bus.stackErr), 32'd0);
    bus.brEn = 1'b1; bus.cond = 1'b1; bus.brIdx = 3'd3;
    #1;
    check("rst_lut_jump", 32'(bus.jumpEn), 32'd1);
    check("rst_lut_tgt", 32'(bus.target), 32'd0);

    // LUT write and branch, including read-before-write
    lut_write(3'd5, 6'h2A);
    bus.brEn = 1'b1; bus.cond = 1'b1; bus.brIdx = 3'd5;
    #1;
    check("br_jump", 32'(bus.jumpEn), 32'd1);
    check("br_tgt", 32'(bus.target), 32'h2A);
    bus.cond = 1'b0;
    #1;
    check("br_nt_jump", 32'(bus.jumpEn), 32'd0);
    check("br_nt_tgt", 32'(bus.target), 32'd0);
    bus.cond = 1'b1;
    bus.lutWrEn = 1'b1; bus.lutWrIdx = 3'd5; bus.lutWrData = 6'h11;
    #1;
    check("rbw_old", 32'(bus.target), 32'h2A);
    tick();
    bus.lutWrEn = 1'b0;
    #1;
    check("rbw_new", 32'(bus.target), 32'h11);
    check("br_stack_empty", 32'(bus.stackEmpty), 32'd1);

    // call/return nesting
    lut_write(3'd1, 6'h10);
    call(6'h05, 6'h10);
    call(6'h12, 6'h10);
    ret(6'h13);
    ret(6'h06);
    #1;
    check("nest_empty", 32'(bus.stackEmpty), 32'd1);

    // overflow
    call(6'h20, 6'h10);
    call(6'h21, 6'h10);
    call(6'h22, 6'h10);
    call(6'h23, 6'h10);
    check("ovf_full", 32'(bus.stackFull), 32'd1);
    check("ovf_err_pre", 32'(bus.stackErr), 32'd0);
    bus.callEn = 1'b1; bus.brIdx = 3'd1; bus.programCounter = 6'h30;
    #1;
    check("ovf_jump", 32'(bus.jumpEn), 32'd0);
    check("ovf_tgt", 32'(bus.target), 32'd0);
    tick();
    idle();
    check("ovf_err", 32'(bus.stackErr), 32'd1);
    check("ovf_full2", 32'(bus.stackFull), 32'd1);
    ret(6'h24);
    ret(6'h23);
    ret(6'h22);
    ret(6'h21);
    check("ovf_empty", 32'(bus.stackEmpty), 32'd1);

    // PC wrap
    call(6'h3F, 6'h10);
    ret(6'h00);

    // underflow
    do_reset();
    bus.retEn = 1'b1;
    #1;
    check("udf_jump", 32'(bus.jumpEn), 32'd0);
    tick();
    idle();
    check("udf_err", 32'(bus.stackErr), 32'd1);
    check("udf_empty", 32'(bus.stackEmpty), 32'd1);

    // priority: ret wins over call and branch
    lut_write(3'd1, 6'h10);
    call(6'h08, 6'h10);
    bus.retEn = 1'b1; bus.callEn = 1'b1; bus.brEn = 1'b1; bus.cond = 1'b1; bus.brIdx = 3'd1;
    bus.programCounter = 6'h2C;
    #1;
    check("prio_jump", 32'(bus.jumpEn), 32'd1);
    check("prio_tgt", 32'(bus.target), 32'h09);
    tick();
    idle();
    check("prio_empty", 32'(bus.stackEmpty), 32'd1);
    check("prio_full", 32'(bus.stackFull), 32'd0);

    // reset mid-operation
    lut_write(3'd2, 6'h07);
    call(6'h01, 6'h10);
    call(6'h02, 6'h10);
    call(6'h03, 6'h10);
    check("mid_err", 32'(bus.stackErr), 32'd1);
    reset = 1'b1;
    bus.callEn = 1'b1; bus.brIdx = 3'd1; bus.programCounter = 6'h04;
    #1;
    check("mid_rst_jump", 32'(bus.jumpEn), 32'd0);
    check("mid_rst_tgt", 32'(bus.target), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("mid_empty", 32'(bus.stackEmpty), 32'd1);
    check("mid_err_clr", 32'(bus.stackErr), 32'd0);
    bus.brEn = 1'b1; bus.cond = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.brIdx = 3'(i);
      #1;
      check("mid_lut_zero", 32'(bus.target), 32'd0);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
